// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: an 8-deep scan-code FIFO feeding a
// frame serialiser that drives registered ps2_clk/ps2_data lines.
//
// Write port handshake: a byte is taken on every rising clk edge where wr_en=1
// and full=0; wr_en=1 while full=0 is never stalled, and wr_en=1 while full=1
// drops the byte and sets the sticky overflow flag.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  STOP_IDX  = 4'd10;

  // FIFO storage and bookkeeping
  logic [7:0] mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       push;
  logic       pop;
  logic [7:0] head;

  // Serialiser state; state_q is the observable FSM state
  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [3:0]  bit_q;
  logic [3:0]  bit_d;
  logic [9:0]  shift_q;
  logic [9:0]  shift_d;
  logic        clk_q;
  logic        clk_d;
  logic        data_q;
  logic        data_d;

  assign full  = (count == 4'd8);
  assign empty = (count == 4'd0);
  assign push  = wr_en & ~full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      if (push && !pop) begin
        count <= count + 4'd1;
      end else if (!push && pop) begin
        count <= count - 4'd1;
      end
      // Full is judged before any same-cycle pop, so a pop cannot rescue a write
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Shift register holds frame bits 1..10 (data LSB first, odd parity, stop);
  // the start bit is driven directly at load time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    clk_d   = clk_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = {1'b1, ~^head, head};
          data_d  = 1'b0;
          clk_d   = 1'b1;
          cnt_d   = 16'd0;
          bit_d   = 4'd0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == HALF_LAST) begin
          clk_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LOW: begin
        if (cnt_q == HALF_LAST) begin
          clk_d = 1'b1;
          cnt_d = 16'd0;
          if (bit_q == STOP_IDX) begin
            data_d  = 1'b1;
            state_d = GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            data_d  = shift_q[0];
            shift_d = {1'b1, shift_q[9:1]};
            state_d = HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 4'd0;
      shift_q <= 10'h3ff;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
Device-side PS/2 transmitter that emulates a keyboard. It accepts scan-code bytes through a write port into an 8-entry FIFO. It serialises each byte onto ps2_clk/ps2_data as an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1. It drives the PS/2 receiver (ps2_keyboard) in simulation and on-board loopback, and is fed by the test-stimulus or host logic.

Parameters:
CLK_DIV, 4, clk cycles per half-period of ps2_clk (each bit cell = 2*CLK_DIV cycles); legal range 2..1023.
GAP_CYCLES, 16, idle clk cycles (both lines high) inserted after each stop bit before the next frame; legal range 1..65535.

Ports:
clk  input  1  system clock; single clock domain.
clrn  input  1  reset, asynchronous, active-low.
wr_en  input  1  write strobe; sampled on the rising edge of clk.
wr_data  input  8  scan-code byte to enqueue.
full  output  1  FIFO holds 8 entries (combinational from count).
empty  output  1  FIFO holds 0 entries (combinational from count).
busy  output  1  FSM not in IDLE (registered state decode).
overflow  output  1  sticky flag: a write was dropped because the FIFO was full.
ps2_clk  output  1  PS/2 clock line, registered; idle high.
ps2_data  output  1  PS/2 data line, registered; idle high.

Behaviour:
- Reset (clrn=0, asynchronous):
  - State = IDLE; FIFO pointers and count = 0.
  - ps2_clk = 1, ps2_data = 1, overflow = 0, busy = 0, empty = 1, full = 0.
  - Reset asserted mid-frame aborts the frame immediately and discards FIFO contents. No partial frame resumes after release.
- FIFO:
  - 8 x 8 bits, 3-bit wrapping read/write pointers, 4-bit count (0..8).
  - Write accepted when wr_en=1 and full=0.
  - wr_en=1 with full=1: byte dropped, overflow set to 1 and held until reset. A pop in the same cycle does not rescue the write.
  - A simultaneous accepted write and pop leaves count unchanged.
- FSM states: IDLE, HIGH, LOW, GAP. Bit index 0..10; half-period counter; frame shift register {1, parity, data[7:0], 0}; parity = ~^data.
- IDLE, on a clock edge with empty=0:
  - Pop the FIFO head and load the shift register.
  - ps2_data <= 0 (start bit), half-counter <= 0, bit index <= 0, go to HIGH.
  - A byte written at edge k is therefore popped at edge k+1 if the FSM was IDLE.
- HIGH: ps2_clk = 1 for CLK_DIV cycles, then ps2_clk <= 0 and go to LOW. The falling edge occurs CLK_DIV cycles after ps2_data changed.
- LOW: ps2_clk = 0 for CLK_DIV cycles, then ps2_clk <= 1.
  - If bit index < 10: bit index++, ps2_data <= next frame bit, go to HIGH. ps2_data only changes while ps2_clk is high.
  - If bit index = 10 (stop bit done): ps2_data <= 1, go to GAP.
- GAP: both lines high for GAP_CYCLES cycles, then go to IDLE. A pending byte is popped on the first IDLE edge.
- Frame length: 22*CLK_DIV cycles from start-bit drive to ps2_clk returning high. Byte-to-byte period when back-to-back = 22*CLK_DIV + GAP_CYCLES + 1.
- busy = 1 from the pop edge until the GAP to IDLE transition.
- Writes are accepted in all states; frames are transmitted strictly in FIFO order.

Test Plan:
1. Defaults, IDLE, write 0x1C once: ps2_data sampled at the 11 ps2_clk falling edges = 0,0,0,1,1,1,0,0,0,0,1 (parity 0). First falling edge 4 cycles after ps2_data goes low; busy high for 88+16 cycles; lines idle high afterwards.
2. Parity check, write 0x00 then 0xF0: parity bits 1 and 1; 0xF0 data bits 0,0,0,0,1,1,1,1. Second start bit begins exactly 105 cycles after the first.
3. Overflow: from IDLE, 10 writes on consecutive cycles with bytes 0x01..0x0A. Bytes 0x01..0x09 accepted (0x01 popped immediately), full=1 after the 9th write, 0x0A dropped, overflow=1 and sticky. Wire output shows 0x01..0x09 in order; empty=1 at the end.
4. Simultaneous write and pop: FIFO empty, IDLE, write on one cycle then write again on the pop edge. Count = 1 after that edge and both bytes are transmitted in order.
5. Reset mid-frame: assert clrn=0 during bit 5 of 0x1C with 3 bytes queued. ps2_clk=ps2_data=1 and empty=1 without waiting for a clock edge. After release the lines stay idle until a new write.
6. Loopback into ps2_keyboard receiver with the sequence 0x1C, 0xF0, 0x1C: receiver data outputs 0x1C, 0xF0, 0x1C with no parity rejects.
